wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 Parameter NB_DATA, 32, register-file data width (multiple of 8, >= 16).
REQ-002 Parameter NB_REG, 5, register-address width.
REQ-003 Parameter NB_PC, 32, PC width (NB_PC <= NB_DATA).
REQ-004 Parameter NB_CNT, 32, retired-instruction counter width.
REQ-005 Ports SHALL be:
- i_clock  in  1  single clock; all state on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_enable  in  1  pipeline advance (debug step/run); 0 = stall.
- i_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble).
- i_reg_write  in  1  instruction writes the register file.
- i_wb_sel  in  2  source select: 0 = ALU, 1 = MEM, 2 = PC link, 3 = ALU.
- i_load_size  in  2  0 = byte, 1 = half, 2/3 = word.
- i_load_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- i_byte_off  in  2  load address bits [1:0].
- i_mem_data  in  NB_DATA  raw memory word.
- i_alu_result  in  NB_DATA  ALU result.
- i_pc  in  NB_PC  link value (already return address).
- i_selected_reg  in  NB_REG  destination register.
- i_halt  in  1  instruction is HALT.
- o_reg_write  out  1  register-file write strobe.
- o_selected_data  out  NB_DATA  write-back data.
- o_selected_reg  out  NB_REG  write-back address.
- o_halted  out  1  halt reached write-back.
- o_retired  out  NB_CNT  retired-instruction count.

Function
REQ-006 Accept = i_enable & i_valid & (state == RUN); all outputs SHALL be registered, latency one cycle from accept.
REQ-007 On accept, o_selected_data/o_selected_reg SHALL load the selected source and i_selected_reg; otherwise both SHALL hold.
REQ-008 o_reg_write SHALL be 1 for exactly one cycle after an accept with i_reg_write = 1, i_halt = 0, i_selected_reg != 0; else 0 (stall, bubble, r0 write, HALTED).
REQ-009 MEM byte: lane i_byte_off (lane 0 = bits [7:0]); half: lane i_byte_off[1], i_byte_off[0] ignored; word: unmodified.
REQ-010 Byte/half SHALL be sign- or zero-extended to NB_DATA per i_load_unsigned; ignored for word.
REQ-011 PC link SHALL be zero-extended from NB_PC to NB_DATA.
REQ-012 o_retired SHALL increment by 1 per accept (HALT included, bubbles excluded) and saturate at all-ones.
REQ-013 FSM states RUN, HALTED; RUN -> HALTED on accept with i_halt = 1; HALTED left only by reset.
REQ-014 o_halted SHALL be 1 in HALTED; data/reg/counter frozen, o_reg_write = 0, inputs ignored.

Reset
REQ-015 On i_clock edge with i_reset = 0: state RUN, o_reg_write 0, o_selected_data 0, o_selected_reg 0, o_halted 0, o_retired 0.
REQ-016 Reset SHALL take priority over a simultaneous accept; the in-flight instruction is discarded and not counted.

Structure
REQ-017 Shared package SHALL hold WB_SEL_ALU/MEM/PC, LOAD_BYTE/HALF/WORD encodings and state encoding.
REQ-018 Load extraction/extension SHALL be one combinational sub-module, load_extend; source mux and FSM in wb_unit.

Verification
REQ-019 Mem data 0x8badf00d, byte, signed, off 3 -> next cycle o_selected_data 0xffffff8b, o_reg_write 1.
REQ-020 Same data, half, unsigned, off 1 -> 0x0000f00d; off 2 -> 0x00008bad.
REQ-021 wb_sel 2, i_pc 0x00000048, reg 31 -> data 0x00000048, reg 31, o_reg_write 1; then i_enable 0 -> o_reg_write 0, data held.
REQ-022 ALU 0x12345678, reg 0, reg_write 1 -> o_reg_write 0, o_retired +1.
REQ-023 Three valid instrs, bubble, HALT, then valid ALU writes -> o_retired 4, o_halted 1, no further o_reg_write.
REQ-024 Force o_retired all-ones (NB_CNT 4: 15), accept -> stays 15; reset low with accept -> all outputs 0.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// Shared encodings for the write-back stage: source select, load size and FSM state.
package wb_unit_pkg;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC  = 2'd2;

   localparam logic [1:0] LOAD_BYTE = 2'd0;
   localparam logic [1:0] LOAD_HALF = 2'd1;
   localparam logic [1:0] LOAD_WORD = 2'd2;

   typedef enum logic {
      StRun,
      StHalted
   } wb_state_e;

endpackage

// File: rtl/wb_unit_if.sv
// Pipeline-side bundle of the write-back stage; master drives the MEM/WB slot, slave is the stage.
interface wb_unit_if #(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_REG  = 5,
   parameter int unsigned NB_PC   = 32,
   parameter int unsigned NB_CNT  = 32
) ();

   logic               i_enable;
   logic               i_valid;
   logic               i_reg_write;
   logic [1:0]         i_wb_sel;
   logic [1:0]         i_load_size;
   logic               i_load_unsigned;
   logic [1:0]         i_byte_off;
   logic [NB_DATA-1:0] i_mem_data;
   logic [NB_DATA-1:0] i_alu_result;
   logic [NB_PC-1:0]   i_pc;
   logic [NB_REG-1:0]  i_selected_reg;
   logic               i_halt;
   logic               o_reg_write;
   logic [NB_DATA-1:0] o_selected_data;
   logic [NB_REG-1:0]  o_selected_reg;
   logic               o_halted;
   logic [NB_CNT-1:0]  o_retired;

   modport master (
      output i_enable, i_valid, i_reg_write, i_wb_sel, i_load_size, i_load_unsigned,
             i_byte_off, i_mem_data, i_alu_result, i_pc, i_selected_reg, i_halt,
      input  o_reg_write, o_selected_data, o_selected_reg, o_halted, o_retired
   );

   modport slave (
      input  i_enable, i_valid, i_reg_write, i_wb_sel, i_load_size, i_load_unsigned,
             i_byte_off, i_mem_data, i_alu_result, i_pc, i_selected_reg, i_halt,
      output o_reg_write, o_selected_data, o_selected_reg, o_halted, o_retired
   );

endinterface

// File: rtl/wb_unit_load_extend.sv
// Combinational load lane extraction with sign/zero extension (little-endian lanes).
module load_extend
   import wb_unit_pkg::*;
#(
   parameter int unsigned NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] mem_data_i,
   input  logic [1:0]         load_size_i,
   input  logic               load_unsigned_i,
   input  logic [1:0]         byte_off_i,
   output logic [NB_DATA-1:0] data_o
);

   logic [NB_DATA-1:0] shift_b;
   logic [NB_DATA-1:0] shift_h;
   logic [7:0]         lane_b;
   logic [15:0]        lane_h;
   logic               sign_b;
   logic               sign_h;

   always_comb begin
      shift_b = mem_data_i >> {byte_off_i, 3'b000};
      // Halfword lane picks on bit 1 only; a misaligned bit 0 is ignored.
      shift_h = mem_data_i >> {byte_off_i[1], 4'b0000};
      lane_b  = shift_b[7:0];
      lane_h  = shift_h[15:0];
      sign_b  = ~load_unsigned_i & lane_b[7];
      sign_h  = ~load_unsigned_i & lane_h[15];
      case (load_size_i)
         LOAD_BYTE: data_o = {{(NB_DATA-8){sign_b}}, lane_b};
         LOAD_HALF: data_o = {{(NB_DATA-16){sign_h}}, lane_h};
         default:   data_o = mem_data_i;
      endcase
   end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: selects result source, drives the register-file write port, counts retires.
module wb_unit
   import wb_unit_pkg::*;
#(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_REG  = 5,
   parameter int unsigned NB_PC   = 32,
   parameter int unsigned NB_CNT  = 32
) (
   input  logic       i_clock,
   input  logic       i_reset,
   wb_unit_if.slave   bus_io
);

   wb_state_e          state_q, state_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic [NB_REG-1:0]  reg_q, reg_d;
   logic               we_q, we_d;
   logic [NB_CNT-1:0]  cnt_q, cnt_d;
   logic [NB_DATA-1:0] load_data;
   logic [NB_DATA-1:0] src_data;
   logic               accept;

   load_extend #(
      .NB_DATA (NB_DATA)
   ) u_load_extend (
      .mem_data_i      (bus_io.i_mem_data),
      .load_size_i     (bus_io.i_load_size),
      .load_unsigned_i (bus_io.i_load_unsigned),
      .byte_off_i      (bus_io.i_byte_off),
      .data_o          (load_data)
   );

   assign accept = bus_io.i_enable & bus_io.i_valid & (state_q == StRun);

   always_comb begin
      case (bus_io.i_wb_sel)
         WB_SEL_MEM: src_data = load_data;
         WB_SEL_PC:  src_data = NB_DATA'(bus_io.i_pc);
         default:    src_data = bus_io.i_alu_result;
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      reg_d   = reg_q;
      we_d    = 1'b0;
      cnt_d   = cnt_q;
      if (accept) begin
         data_d = src_data;
         reg_d  = bus_io.i_selected_reg;
         // r0 is hardwired zero and HALT never writes back.
         we_d   = bus_io.i_reg_write & ~bus_io.i_halt & (bus_io.i_selected_reg != '0);
         cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + NB_CNT'(1);
         if (bus_io.i_halt) begin
            state_d = StHalted;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q <= StRun;
         data_q  <= '0;
         reg_q   <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         reg_q   <= reg_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus_io.o_reg_write     = we_q;
   assign bus_io.o_selected_data = data_q;
   assign bus_io.o_selected_reg  = reg_q;
   assign bus_io.o_halted        = (state_q == StHalted);
   assign bus_io.o_retired       = cnt_q;

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: directed and random slots against a behavioural model.
module tb_wb_unit;

   logic clk;
   logic rst_n;

   wb_unit_if #(.NB_DATA(32), .NB_REG(5), .NB_PC(32), .NB_CNT(4)) bus ();

   wb_unit #(
      .NB_DATA (32),
      .NB_REG  (5),
      .NB_PC   (32),
      .NB_CNT  (4)
   ) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus_io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] data;
      logic [4:0]  rg;
      logic        halted;
      logic [3:0]  ret;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Model state
   logic        m_halted = 1'b0;
   logic [31:0] m_data   = 32'h0;
   logic [4:0]  m_reg    = 5'h0;
   logic        m_we     = 1'b0;
   int          m_ret    = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] model_src(logic [1:0] sel, logic [1:0] size, logic uns,
                                             logic [1:0] off, logic [31:0] mem,
                                             logic [31:0] alu, logic [31:0] pc);
      logic [31:0] v;
      if (sel == 2'd2) return pc;
      if (sel != 2'd1) return alu;
      if (size >= 2'd2) return mem;
      if (size == 2'd0) begin
         v = (mem >> (8 * off)) & 32'hff;
         if (!uns && v >= 32'd128) v = v - 32'd256;
      end else begin
         v = (mem >> (16 * off[1])) & 32'hffff;
         if (!uns && v >= 32'd32768) v = v - 32'd65536;
      end
      return v;
   endfunction

   task automatic step(input logic rst, input logic en, input logic val, input logic rw,
                       input logic [1:0] sel, input logic [1:0] size, input logic uns,
                       input logic [1:0] off, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [4:0] rg, input logic halt);
      exp_t e;
      @(negedge clk);
      rst_n                = rst;
      bus.i_enable         = en;
      bus.i_valid          = val;
      bus.i_reg_write      = rw;
      bus.i_wb_sel         = sel;
      bus.i_load_size      = size;
      bus.i_load_unsigned  = uns;
      bus.i_byte_off       = off;
      bus.i_mem_data       = mem;
      bus.i_alu_result     = alu;
      bus.i_pc             = pc;
      bus.i_selected_reg   = rg;
      bus.i_halt           = halt;
      if (!rst) begin
         m_halted = 1'b0; m_data = '0; m_reg = '0; m_we = 1'b0; m_ret = 0;
      end else if (en && val && !m_halted) begin
         m_data = model_src(sel, size, uns, off, mem, alu, pc);
         m_reg  = rg;
         m_we   = rw && !halt && (rg != 0);
         if (m_ret < 15) m_ret++;
         if (halt) m_halted = 1'b1;
      end else begin
         m_we = 1'b0;
      end
      e.we = m_we; e.data = m_data; e.rg = m_reg; e.halted = m_halted; e.ret = 4'(m_ret);
      exp_q.push_back(e);
   endtask

   task automatic alu_op(input logic [31:0] alu, input logic [4:0] rg, input logic halt);
      step(1, 1, 1, 1, 2'd0, 2'd2, 0, 2'd0, 32'h0, alu, 32'h0, rg, halt);
   endtask

   task automatic rand_step();
      logic [31:0] r;
      r = $urandom();
      step(r[11:6] != 6'd0, r[20] | r[21], r[22] | r[23], r[24], r[26:25], r[28:27], r[29],
           r[31:30], $urandom(), $urandom(), $urandom(), r[16:12], r[5:0] == 6'd0);
   endtask

   // Monitor: every cycle the DUT presents a registered result for the previous slot.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("reg_write", 32'(bus.o_reg_write), 32'(e.we));
            chk("data",      bus.o_selected_data,  e.data);
            chk("reg",       32'(bus.o_selected_reg), 32'(e.rg));
            chk("halted",    32'(bus.o_halted),    32'(e.halted));
            chk("retired",   32'(bus.o_retired),   32'(e.ret));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.i_enable = 0; bus.i_valid = 0; bus.i_reg_write = 0; bus.i_wb_sel = 0;
      bus.i_load_size = 0; bus.i_load_unsigned = 0; bus.i_byte_off = 0; bus.i_mem_data = 0;
      bus.i_alu_result = 0; bus.i_pc = 0; bus.i_selected_reg = 0; bus.i_halt = 0;

      // Reset with an accept-looking slot: must be discarded.
      step(0, 1, 1, 1, 2'd0, 2'd2, 0, 2'd0, 32'h0, 32'hdeadbeef, 32'h0, 5'd3, 0);
      step(0, 1, 1, 1, 2'd0, 2'd2, 0, 2'd0, 32'h0, 32'hdeadbeef, 32'h0, 5'd3, 0);

      // Loads from 0x8badf00d
      step(1, 1, 1, 1, 2'd1, 2'd0, 0, 2'd3, 32'h8badf00d, 32'h0, 32'h0, 5'd5, 0);
      step(1, 1, 1, 1, 2'd1, 2'd1, 1, 2'd1, 32'h8badf00d, 32'h0, 32'h0, 5'd6, 0);
      step(1, 1, 1, 1, 2'd1, 2'd1, 1, 2'd2, 32'h8badf00d, 32'h0, 32'h0, 5'd7, 0);
      step(1, 1, 1, 1, 2'd1, 2'd0, 1, 2'd0, 32'h8badf00d, 32'h0, 32'h0, 5'd8, 0);
      step(1, 1, 1, 1, 2'd1, 2'd1, 0, 2'd3, 32'h8badf00d, 32'h0, 32'h0, 5'd9, 0);
      step(1, 1, 1, 1, 2'd1, 2'd3, 0, 2'd1, 32'h8badf00d, 32'h0, 32'h0, 5'd10, 0);

      // PC link, then stall holds data
      step(1, 1, 1, 1, 2'd2, 2'd0, 0, 2'd0, 32'h0, 32'h11111111, 32'h00000048, 5'd31, 0);
      step(1, 0, 1, 1, 2'd0, 2'd0, 0, 2'd0, 32'h0, 32'h22222222, 32'h0, 5'd4, 0);
      // wb_sel 3 selects ALU; r0 write suppressed but retired
      step(1, 1, 1, 1, 2'd3, 2'd0, 0, 2'd0, 32'h0, 32'hcafef00d, 32'h0, 5'd2, 0);
      alu_op(32'h12345678, 5'd0, 0);

      // Three valid, bubble, HALT, then writes that must be ignored
      step(0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
      alu_op(32'h1, 5'd1, 0);
      alu_op(32'h2, 5'd2, 0);
      alu_op(32'h3, 5'd3, 0);
      step(1, 1, 0, 1, 2'd0, 2'd0, 0, 2'd0, 32'h0, 32'h4, 32'h0, 5'd4, 0);
      alu_op(32'h5, 5'd5, 1);
      for (int i = 0; i < 4; i++) alu_op(32'h100 + 32'(i), 5'd6, 0);

      // Saturation, then reset over a live accept
      step(0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
      for (int i = 0; i < 18; i++) alu_op(32'(i), 5'd12, 0);
      step(0, 1, 1, 1, 2'd0, 2'd2, 0, 2'd0, 32'h0, 32'h77, 32'h0, 5'd12, 0);

      for (int i = 0; i < 400; i++) rand_step();

      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain actual=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
